// File: rtl/str_buf_pkg.sv
// Shared constants and state type for the string buffer.
// Feature macro: STR_BUF_CASEFOLD_EN (enables upper-case folding of loaded characters).
package str_pkg;

    localparam logic [7:0] PAD_DEFAULT = 8'h20;
    localparam logic [7:0] LOWER_A     = 8'h61;
    localparam logic [7:0] LOWER_Z     = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } str_state_e;

endpackage

// File: rtl/str_buf_if.sv
// Character load handshake and random-access read port of the string buffer.
// master = producer/reader side, slave = buffer side.
interface str_buf_if #(
    parameter int CW = 8,
    parameter int LW = 6
);
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_char;
    logic          in_last;
    logic          rd_en;
    logic [LW-1:0] rd_idx;
    logic [CW-1:0] rd_char;
    logic          rd_valid;

    modport master (
        output in_valid, in_char, in_last, rd_en, rd_idx,
        input  in_ready, rd_char, rd_valid
    );

    modport slave (
        input  in_valid, in_char, in_last, rd_en, rd_idx,
        output in_ready, rd_char, rd_valid
    );
endinterface

// File: rtl/str_buf_casefold.sv
// Purpose: folds ASCII lower-case letters to upper case; pass-through when CW != 8.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the input character.
module str_casefold
    import str_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0] din,
    output logic [CW-1:0] dout
);

    if (CW == 8) begin : g_fold
        assign dout = (din >= LOWER_A && din <= LOWER_Z) ? din - CASE_OFFSET : din;
    end else begin : g_pass
        assign dout = din;
    end

endmodule

// File: rtl/str_buf.sv
// Purpose: serially loads one string into DEPTH pad-filled slots; flat view plus registered read port.
// Latency: char visible in str_flat one cycle after accept; rd_char/rd_valid one cycle after rd_en.
// Backpressure: in_ready is low only while clr is asserted. Optional fold: STR_BUF_CASEFOLD_EN.
module str_buf
    import str_pkg::*;
#(
    parameter int            DEPTH    = 40,
    parameter int            CW       = 8,
    parameter logic [CW-1:0] PAD_CHAR = CW'(PAD_DEFAULT),
    parameter int            LW       = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    str_buf_if.slave            bus,
    output logic                str_valid,
    output logic [LW-1:0]       len,
    output logic                ovf,
    output logic [DEPTH*CW-1:0] str_flat
);

    str_state_e                state;
    str_state_e                state_nxt;
    logic [DEPTH-1:0][CW-1:0]  slots;
    logic [LW-1:0]             wr_ptr;
    logic [CW-1:0]             ch;
    logic [CW-1:0]             rd_sel;
    logic                      accept;
    logic                      start;
    logic                      append;
    logic                      ptr_full;

`ifdef STR_BUF_CASEFOLD_EN
    str_casefold #(.CW(CW)) u_fold (
        .din  (bus.in_char),
        .dout (ch)
    );
`else
    assign ch = bus.in_char;
`endif

    assign bus.in_ready = ~clr;
    assign accept       = bus.in_valid & ~clr;
    assign ptr_full     = (wr_ptr == LW'(DEPTH));
    assign str_flat     = slots;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        append    = 1'b0;
        if (clr) begin
            state_nxt = IDLE;
        end else if (accept) begin
            case (state)
                IDLE, DONE: begin
                    start     = 1'b1;
                    state_nxt = bus.in_last ? DONE : LOAD;
                end
                LOAD: begin
                    append = 1'b1;
                    if (bus.in_last) begin
                        state_nxt = DONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A new first character wipes the previous string so stale tail slots never survive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slots     <= {DEPTH{PAD_CHAR}};
            wr_ptr    <= '0;
            len       <= '0;
            ovf       <= 1'b0;
            str_valid <= 1'b0;
        end else if (clr) begin
            slots     <= {DEPTH{PAD_CHAR}};
            wr_ptr    <= '0;
            len       <= '0;
            ovf       <= 1'b0;
            str_valid <= 1'b0;
        end else if (start) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= (i == 0) ? ch : PAD_CHAR;
            end
            wr_ptr    <= LW'(1);
            ovf       <= 1'b0;
            str_valid <= bus.in_last;
            len       <= bus.in_last ? LW'(1) : '0;
        end else if (append) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ptr == LW'(i)) begin
                    slots[i] <= ch;
                end
            end
            if (ptr_full) begin
                ovf <= 1'b1;
            end else begin
                wr_ptr <= wr_ptr + LW'(1);
            end
            if (bus.in_last) begin
                len       <= ptr_full ? wr_ptr : wr_ptr + LW'(1);
                str_valid <= 1'b1;
            end
        end
    end

    // Out-of-range indices fall through to the pad value.
    always_comb begin
        rd_sel = PAD_CHAR;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rd_idx == LW'(i)) begin
                rd_sel = slots[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rd_valid <= 1'b0;
            bus.rd_char  <= PAD_CHAR;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.rd_char <= rd_sel;
            end
        end
    end

endmodule

// File: tb/tb_str_buf.sv
// Self-checking bench for str_buf: vector table, directed corner sequences, random traffic vs queue model.
module tb_str_buf;
    localparam int DEPTH = 40;
    localparam int CW    = 8;
    localparam int LW    = 6;
    localparam int FW    = DEPTH * CW;

    logic          clk;
    logic          rst;
    logic          clr;
    logic          str_valid;
    logic [LW-1:0] len;
    logic          ovf;
    logic [FW-1:0] str_flat;

    str_buf_if #(.CW(CW), .LW(LW)) bus ();

    str_buf #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .bus       (bus),
        .str_valid (str_valid),
        .len       (len),
        .ovf       (ovf),
        .str_flat  (str_flat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [FW-1:0] act, logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference model: the string is a queue of stored characters.
    logic [7:0] m_str[$];
    bit         m_loading;
    bit         m_done;
    bit         m_ovf;
    int         m_len;
    bit         m_rdv;
    logic [7:0] m_rdc;

    function automatic logic [7:0] m_slot(int i);
        if (i < m_str.size()) return m_str[i];
        return 8'h20;
    endfunction

    function automatic logic [FW-1:0] m_flat();
        logic [FW-1:0] f;
        for (int i = 0; i < DEPTH; i++) f[i*CW +: CW] = m_slot(i);
        return f;
    endfunction

    task automatic m_reset();
        m_str.delete();
        m_loading = 0;
        m_done    = 0;
        m_ovf     = 0;
        m_len     = 0;
        m_rdv     = 0;
        m_rdc     = 8'h20;
    endtask

    task automatic model_edge(bit v, logic [7:0] c, bit last, bit cl, bit re, int idx);
        m_rdv = re;
        if (re) m_rdc = m_slot(idx);
        if (cl) begin
            m_str.delete();
            m_loading = 0;
            m_done    = 0;
            m_ovf     = 0;
            m_len     = 0;
        end else if (v) begin
            if (!m_loading) begin
                m_str.delete();
                m_str.push_back(c);
                m_ovf     = 0;
                m_done    = 0;
                m_len     = 0;
                m_loading = 1;
            end else if (m_str.size() < DEPTH) begin
                m_str.push_back(c);
            end else begin
                m_ovf = 1;
            end
            if (last) begin
                m_loading = 0;
                m_done    = 1;
                m_len     = m_str.size();
            end
        end
    endtask

    task automatic check_model();
        chk("str_valid", FW'(str_valid), FW'(m_done));
        chk("len", FW'(len), FW'(m_len));
        chk("ovf", FW'(ovf), FW'(m_ovf));
        chk("str_flat", str_flat, m_flat());
        chk("rd_valid", FW'(bus.rd_valid), FW'(m_rdv));
        if (m_rdv) chk("rd_char", FW'(bus.rd_char), FW'(m_rdc));
    endtask

    task automatic cyc(bit v, logic [7:0] c, bit last, bit cl, bit re, int idx);
        bus.in_valid = v;
        bus.in_char  = c;
        bus.in_last  = last;
        clr          = cl;
        bus.rd_en    = re;
        bus.rd_idx   = idx[LW-1:0];
        #1;
        chk("in_ready", FW'(bus.in_ready), FW'(!cl));
        model_edge(v, c, last, cl, re, idx);
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        bit         v;
        logic [7:0] c;
        bit         last;
        bit         cl;
        bit         re;
        int         idx;
        bit         e_sv;
        int         e_len;
        bit         e_ovf;
        bit         e_rdv;
        logic [7:0] e_rdc;
    } vec_t;

    vec_t          tbl[17];
    logic [FW-1:0] pad_flat;
    int            lastmod;

    initial begin
        pad_flat = {DEPTH{8'h20}};
        tbl[0]  = '{1, 8'h41, 0, 0, 0, 0,  0, 0, 0, 0, 8'h20};
        tbl[1]  = '{1, 8'h42, 0, 0, 0, 0,  0, 0, 0, 0, 8'h20};
        tbl[2]  = '{1, 8'h43, 1, 0, 0, 0,  1, 3, 0, 0, 8'h20};
        tbl[3]  = '{0, 8'h00, 0, 0, 1, 1,  1, 3, 0, 1, 8'h42};
        tbl[4]  = '{0, 8'h00, 0, 0, 1, 5,  1, 3, 0, 1, 8'h20};
        tbl[5]  = '{0, 8'h00, 0, 0, 1, 45, 1, 3, 0, 1, 8'h20};
        tbl[6]  = '{0, 8'h00, 0, 0, 0, 0,  1, 3, 0, 0, 8'h20};
        tbl[7]  = '{1, 8'h48, 0, 0, 0, 0,  0, 0, 0, 0, 8'h20};
        tbl[8]  = '{1, 8'h45, 0, 0, 0, 0,  0, 0, 0, 0, 8'h20};
        tbl[9]  = '{1, 8'h4C, 0, 0, 0, 0,  0, 0, 0, 0, 8'h20};
        tbl[10] = '{1, 8'h4C, 0, 0, 0, 0,  0, 0, 0, 0, 8'h20};
        tbl[11] = '{1, 8'h4F, 1, 0, 1, 4,  1, 5, 0, 1, 8'h20};
        tbl[12] = '{1, 8'h48, 0, 0, 1, 4,  0, 0, 0, 1, 8'h4F};
        tbl[13] = '{1, 8'h49, 1, 0, 0, 0,  1, 2, 0, 0, 8'h20};
        tbl[14] = '{0, 8'h00, 0, 0, 1, 4,  1, 2, 0, 1, 8'h20};
        tbl[15] = '{0, 8'h00, 0, 0, 1, 1,  1, 2, 0, 1, 8'h49};
        tbl[16] = '{0, 8'h00, 0, 1, 0, 0,  0, 0, 0, 0, 8'h20};

        rst          = 1'b0;
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_char  = '0;
        bus.in_last  = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_idx   = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        chk("rst_rd_char", FW'(bus.rd_char), FW'(8'h20));
        #2 rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].v, tbl[i].c, tbl[i].last, tbl[i].cl, tbl[i].re, tbl[i].idx);
            chk($sformatf("tbl%0d_sv", i), FW'(str_valid), FW'(tbl[i].e_sv));
            chk($sformatf("tbl%0d_len", i), FW'(len), FW'(tbl[i].e_len));
            chk($sformatf("tbl%0d_ovf", i), FW'(ovf), FW'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d_rdv", i), FW'(bus.rd_valid), FW'(tbl[i].e_rdv));
            if (tbl[i].e_rdv) chk($sformatf("tbl%0d_rdc", i), FW'(bus.rd_char), FW'(tbl[i].e_rdc));
        end

        // 45 characters into a 40-slot buffer.
        for (int k = 0; k < 45; k++) begin
            cyc(1, 8'h61 + 8'(k), k == 44, 0, 0, 0);
        end
        chk("ovf_len", FW'(len), FW'(40));
        chk("ovf_flag", FW'(ovf), FW'(1));
        cyc(0, 8'h00, 0, 0, 1, 39);
        chk("ovf_slot39", FW'(bus.rd_char), FW'(8'h88));

        // clr mid-load while a character is offered.
        cyc(1, 8'h58, 0, 0, 0, 0);
        cyc(1, 8'h59, 0, 0, 0, 0);
        cyc(1, 8'h5A, 0, 1, 0, 0);
        chk("clr_len", FW'(len), FW'(0));
        chk("clr_flat", str_flat, pad_flat);
        cyc(1, 8'h51, 1, 0, 0, 0);
        chk("clr_restart_len", FW'(len), FW'(1));

        // Asynchronous reset in the middle of a load.
        cyc(1, 8'h4D, 0, 0, 1, 0);
        cyc(1, 8'h4E, 0, 0, 1, 0);
        #2 rst = 1'b0;
        #1;
        chk("arst_sv", FW'(str_valid), FW'(0));
        chk("arst_len", FW'(len), FW'(0));
        chk("arst_flat", str_flat, pad_flat);
        chk("arst_rdv", FW'(bus.rd_valid), FW'(0));
        chk("arst_rdc", FW'(bus.rd_char), FW'(8'h20));
        m_reset();
        @(posedge clk);
        #3 rst = 1'b1;

        // Random traffic; the second half uses rare in_last to reach overflow.
        for (int n = 0; n < 1200; n++) begin
            lastmod = (n < 600) ? 8 : 64;
            cyc($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, lastmod - 1) == 0,
                $urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 47));
        end

        bus.in_valid = 1'b0;
        bus.rd_en    = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/str_buf.md
Name: str_buf

Overview:
- Parametrised character buffer for the string-matching engine. It loads one target string serially through a valid/ready handshake and records its length.
- It presents the string as a flattened parallel vector for the matcher, plus a registered random-access read port.
- Generalises the fixed 40x8 string register with: configurable depth and char width, explicit load state machine, clear command, overflow detection, and pad-filled tail.

Parameters:
- DEPTH, 40, number of character slots
- CW, 8, character width in bits
- PAD_CHAR, 8'h20, value of unused slots (space)
- LW, $clog2(DEPTH+1), width of length and index ports (derived, do not override)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of buffer, length and flags
- in_valid  in  1  character present on in_char
- in_ready  out  1  buffer accepts a character this cycle
- in_char  in  CW  incoming character
- in_last  in  1  qualifies in_char as final character of the string
- str_valid  out  1  complete string held
- len  out  LW  number of stored characters, 0..DEPTH
- ovf  out  1  sticky: string exceeded DEPTH, tail dropped
- str_flat  out  DEPTH*CW  slot i at bits [i*CW +: CW]
- rd_en  in  1  read request
- rd_idx  in  LW  read slot index
- rd_char  out  CW  read data, one cycle after rd_en
- rd_valid  out  1  rd_char valid, one cycle after rd_en

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all slots=PAD_CHAR; len=0; wr_ptr=0
  - str_valid=0, ovf=0, rd_valid=0, rd_char=PAD_CHAR
- Accept = in_valid & in_ready. in_ready=1 in every state except during clr.
- FSM states: IDLE, LOAD, DONE.
  - IDLE/DONE + accept:
    - slot0=in_char; all other slots=PAD_CHAR (same edge); wr_ptr=1; ovf=0; str_valid=0
    - in_last=1 -> DONE, len=1, str_valid=1; otherwise -> LOAD
  - LOAD + accept:
    - If wr_ptr<DEPTH: slot[wr_ptr]=in_char, wr_ptr++
    - Else: char dropped, ovf=1
    - If in_last: len=wr_ptr after this write (saturates at DEPTH), -> DONE, str_valid=1 next cycle
  - LOAD, no accept: hold.
  - DONE: holds string, len, str_valid=1 until a new first char or clr.
- clr has priority over in_valid and reset-equivalent behaviour except async. Next cycle: state=IDLE, slots=PAD_CHAR, len=0, ovf=0, str_valid=0. In-flight load is aborted.
- Slots at index >= len always read PAD_CHAR once DONE.
- str_flat is a direct register view. During LOAD it reflects the partial string.
- Read port:
  - rd_en at edge t -> rd_valid=1 and rd_char=slot[rd_idx] at t+1.
  - rd_idx>=DEPTH returns PAD_CHAR.
  - Legal in any state; a same-edge write is not forwarded (old value returned).
- Reset mid-load: buffer returns to reset state immediately; no partial length retained.
- wr_ptr is LW bits and saturates at DEPTH (no wrap).

Optional Feature:
- STR_BUF_CASEFOLD_EN defined:
  - in_char in 8'h61..8'h7A is stored as in_char-8'h20 (upper case); all other values unchanged.
  - Applies only when CW==8; ignored otherwise.
- Undefined: characters stored verbatim.

Decomposition:
- Package str_pkg holds:
  - PAD_CHAR default, ASCII range constants (LOWER_A, LOWER_Z, CASE_OFFSET)
  - state enum typedef str_state_e {IDLE, LOAD, DONE}
- Sub-module str_casefold: combinational CW-bit fold stage, instantiated on in_char only under STR_BUF_CASEFOLD_EN.

Test Plan:
- Load "ABC" (41,42,43, last on 43) -> DONE, len=3, str_valid=1, slots 3..39=20, ovf=0.
- Feed 45 chars 'a'..; last on 45th, DEPTH=40 -> len=40, ovf=1, slot39=40th char, chars 41..45 absent.
- Load "HELLO", then "HI" -> len=2, slot2..4=20. str_valid drops to 0 the cycle after 'H' is accepted.
- Assert clr mid-load after 2 chars with in_valid=1 -> next cycle IDLE, len=0, all slots 20, char ignored.
- After "ABC": rd_en idx=1 -> rd_char=42 next cycle; idx=5 -> 20; idx=45 -> 20; rd_valid pulses each time.
- rst low mid-load -> outputs at reset values asynchronously.
- With STR_BUF_CASEFOLD_EN, load "aZ{" -> slots 41,5A,7B.
